// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer geometry and colour
// constants used by both the scan-out path and the game FSM.
package vga_pkg;

   localparam int unsigned H_ACT  = 640;
   localparam int unsigned H_FP   = 16;
   localparam int unsigned H_SYNC = 96;
   localparam int unsigned H_BP   = 48;
   localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACT  = 480;
   localparam int unsigned V_FP   = 10;
   localparam int unsigned V_SYNC = 2;
   localparam int unsigned V_BP   = 33;
   localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;

   localparam int unsigned FB_W = 176;
   localparam int unsigned FB_H = 120;

   localparam int unsigned CNT_W = 10;

   localparam logic [2:0] colour_object = 3'b111;
   localparam logic [2:0] colour_screen = 3'b000;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic win;
      logic first;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, win: 1'b0, first: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 pixel/line counters with raw (unregistered) sync and
// active-video decode for 640x480@60.
module vga_timing
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcnt,
   output logic [CNT_W-1:0] vcnt,
   output logic             hsync_raw,
   output logic             vsync_raw,
   output logic             de_raw
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == CNT_W'(H_TOT - 1)) begin
         hcnt <= '0;
         vcnt <= (vcnt == CNT_W'(V_TOT - 1)) ? '0 : vcnt + CNT_W'(1);
      end else begin
         hcnt <= hcnt + CNT_W'(1);
      end
   end

   always_comb begin
      hsync_raw = !((hcnt >= CNT_W'(H_ACT + H_FP)) && (hcnt < CNT_W'(H_ACT + H_FP + H_SYNC)));
      vsync_raw = !((vcnt >= CNT_W'(V_ACT + V_FP)) && (vcnt < CNT_W'(V_ACT + V_FP + V_SYNC)));
      de_raw    = (hcnt < CNT_W'(H_ACT)) && (vcnt < CNT_W'(V_ACT));
   end

endmodule

// File: rtl/vga_fb_scanout.sv
// Frame-buffer read side: scaled multiplier-free address generation, 2-stage
// control delay matched to the 1-cycle RAM, and registered VGA pins.
module vga_fb_scanout
   import vga_pkg::*;
#(
   parameter int unsigned     AW         = 15,
   parameter int unsigned     DW         = 3,
   parameter int unsigned     FB_W       = 176,
   parameter int unsigned     FB_H       = 120,
   parameter int unsigned     SCALE_X    = 3,
   parameter int unsigned     SCALE_Y    = 4,
   parameter logic [DW-1:0]   BORDER_RGB = 3'b001
)(
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] mem_px_addr,
   input  logic [DW-1:0] mem_px_data,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic [DW-1:0] vga_rgb,
   output logic          vga_de,
   output logic          frame_start
);

   localparam int unsigned WIN_W = FB_W * SCALE_X;
   localparam int unsigned WIN_H = FB_H * SCALE_Y;
   localparam int unsigned SXW   = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
   localparam int unsigned SYW   = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
   localparam int unsigned CW    = $clog2(FB_W + 1);

   logic [CNT_W-1:0] hcnt, vcnt, h_next, v_next;
   logic             hsync_raw, vsync_raw, de_raw;
   logic             line_end, frame_end, win, win_next;
   logic [SXW-1:0]   sx, sx_n;
   logic [SYW-1:0]   sy, sy_n;
   logic [CW-1:0]    col, col_n;
   logic [AW-1:0]    row_base, row_base_n;
   ctl_t             ctl0, ctl1;

   vga_timing u_timing (
      .clk       (clk),
      .rst       (rst),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .hsync_raw (hsync_raw),
      .vsync_raw (vsync_raw),
      .de_raw    (de_raw)
   );

   always_comb begin
      line_end  = (hcnt == CNT_W'(H_TOT - 1));
      frame_end = line_end && (vcnt == CNT_W'(V_TOT - 1));
      h_next    = line_end ? '0 : hcnt + CNT_W'(1);
      v_next    = line_end ? (frame_end ? '0 : vcnt + CNT_W'(1)) : vcnt;
      win       = (hcnt < CNT_W'(WIN_W)) && (vcnt < CNT_W'(WIN_H));
      win_next  = (h_next < CNT_W'(WIN_W)) && (v_next < CNT_W'(WIN_H));
      ctl0      = '{hsync: hsync_raw, vsync: vsync_raw, de: de_raw, win: win,
                    first: (hcnt == '0) && (vcnt == '0)};
   end

   // sx/col/sy/row_base describe the pixel currently in stage 0; *_n is the next pixel
   always_comb begin
      sx_n       = sx;
      col_n      = col;
      sy_n       = sy;
      row_base_n = row_base;
      if (line_end) begin
         sx_n  = '0;
         col_n = '0;
         if (frame_end) begin
            sy_n       = '0;
            row_base_n = '0;
         end else if (vcnt < CNT_W'(WIN_H)) begin
            if (sy == SYW'(SCALE_Y - 1)) begin
               sy_n       = '0;
               row_base_n = row_base + AW'(FB_W);
            end else begin
               sy_n = sy + SYW'(1);
            end
         end
      end else if (hcnt < CNT_W'(WIN_W)) begin
         if (sx == SXW'(SCALE_X - 1)) begin
            sx_n  = '0;
            col_n = col + CW'(1);
         end else begin
            sx_n = sx + SXW'(1);
         end
      end
   end

   // The address is built from next-pixel state so it is presented in the same
   // cycle as its pixel's counters; the RAM's read cycle then lines up with stage 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sx          <= '0;
         col         <= '0;
         sy          <= '0;
         row_base    <= '0;
         mem_px_addr <= '0;
      end else begin
         sx       <= sx_n;
         col      <= col_n;
         sy       <= sy_n;
         row_base <= row_base_n;
         if (win_next) begin
            mem_px_addr <= row_base_n + AW'(col_n);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctl1        <= CTL_IDLE;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_de      <= 1'b0;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         ctl1        <= ctl0;
         vga_hsync   <= ctl1.hsync;
         vga_vsync   <= ctl1.vsync;
         vga_de      <= ctl1.de;
         vga_rgb     <= ctl1.de ? (ctl1.win ? mem_px_data : BORDER_RGB) : '0;
         frame_start <= ctl1.first;
      end
   end

endmodule
